// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the UART program loader: sync byte, FSM state
// encodings and the baud divisor helper.
package loader_pkg;

  localparam logic [7:0] LDR_SYNC = 8'hA5;

  // Frame-level loader states
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} ldr_state_t;

  // Byte receiver states
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Clocks per serial bit, truncated
  function automatic int DIV(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// BRAM port B write bus plus loader status, driven by the loader (master)
// and consumed by the BRAM / CPU glue (slave).
interface uart_prog_loader_if #(
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              ram_we;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [8:0]        byte_cnt;

  modport master (
    output ram_addr, ram_data, ram_we, cpu_hold, load_done, load_err, byte_cnt
  );

  modport slave (
    input ram_addr, ram_data, ram_we, cpu_hold, load_done, load_err, byte_cnt
  );
endinterface

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART byte receiver: 2-flop synchronizer, start-edge detect with
// mid-start glitch rejection, bit timer and LSB-first shift register.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] data_byte,
  output logic       frame_ok
);

  localparam int DIVISOR = DIV(CLK_HZ, BAUD);
  localparam int CW      = $clog2(DIVISOR + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(DIVISOR - 1);

  logic      r_sync1, r_sync2, r_prev;
  rx_state_t r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [2:0]    r_bit, w_bit_next;
  logic [7:0]    r_shift, w_shift_next;
  logic          r_valid, w_valid_next;
  logic [7:0]    r_byte, w_byte_next;
  logic          r_ok, w_ok_next;

  // Synchronize the asynchronous line; r_prev gives the falling-edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Receiver state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_byte  <= '0;
      r_ok    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_valid <= w_valid_next;
      r_byte  <= w_byte_next;
      r_ok    <= w_ok_next;
    end
  end

  // Bit timing: half a bit to the start midpoint, then a full bit per sample
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + CW'(1);
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_valid_next = 1'b0;
    w_byte_next  = r_byte;
    w_ok_next    = r_ok;
    case (r_state)
      RX_IDLE: begin
        w_cnt_next = '0;
        if (r_prev && !r_sync2) w_state_next = RX_START;
      end
      RX_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_next = '0;
          w_bit_next = '0;
          // A line already back high at mid-start was only a glitch
          w_state_next = r_sync2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == FULL_LAST) begin
          w_cnt_next   = '0;
          w_shift_next = {r_sync2, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_next = RX_STOP;
          else               w_bit_next   = r_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (r_cnt == FULL_LAST) begin
          w_valid_next = 1'b1;
          w_byte_next  = r_shift;
          w_ok_next    = r_sync2;
          w_state_next = RX_IDLE;
        end
      end
      default: w_state_next = RX_IDLE;
    endcase
  end

  assign byte_valid = r_valid;
  assign data_byte  = r_byte;
  assign frame_ok   = r_ok;

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader top: parses A5/len/data[/checksum] frames from the
// byte receiver and writes data bytes into program BRAM port B while
// holding the CPU. Optional feature macro: LOADER_CHECKSUM_EN (adds the
// trailing checksum byte and its comparison).
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rxd,
  uart_prog_loader_if.master  bus
);

  logic       w_byte_valid, w_frame_ok;
  logic [7:0] w_rx_byte;

  uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .byte_valid (w_byte_valid),
    .data_byte  (w_rx_byte),
    .frame_ok   (w_frame_ok)
  );

  ldr_state_t        r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [7:0]        r_data, w_data_next;
  logic              r_we, w_we_next;
  logic [8:0]        r_len, w_len_next;
  logic [8:0]        r_cnt, w_cnt_next;
  logic              r_hold, w_hold_next;
  logic              r_done, w_done_next;
  logic              r_err, w_err_next;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_sum, w_sum_next;
`endif

  logic w_sync_seen;
  assign w_sync_seen = w_byte_valid && w_frame_ok && (w_rx_byte == LDR_SYNC);

  // Frame state and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_hold  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_data  <= w_data_next;
      r_we    <= w_we_next;
      r_len   <= w_len_next;
      r_cnt   <= w_cnt_next;
      r_hold  <= w_hold_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
`ifdef LOADER_CHECKSUM_EN
      r_sum   <= w_sum_next;
`endif
    end
  end

  // Frame parser; the address advances the cycle after each write pulse
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_we ? r_addr + ADDR_W'(1) : r_addr;
    w_data_next  = r_data;
    w_we_next    = 1'b0;
    w_len_next   = r_len;
    w_cnt_next   = r_cnt;
    w_hold_next  = r_hold;
    w_done_next  = r_done;
    w_err_next   = r_err;
`ifdef LOADER_CHECKSUM_EN
    w_sum_next   = r_sum;
`endif
    case (r_state)
      IDLE, DONE, ERR: begin
        if (w_sync_seen) begin
          w_state_next = LEN;
          w_hold_next  = 1'b1;
          w_done_next  = 1'b0;
          w_err_next   = 1'b0;
        end
      end
      LEN: begin
        if (w_byte_valid) begin
          if (!w_frame_ok) begin
            w_state_next = ERR;
            w_err_next   = 1'b1;
          end else begin
            w_len_next   = (w_rx_byte == 8'd0) ? 9'd256 : {1'b0, w_rx_byte};
            w_addr_next  = '0;
            w_cnt_next   = '0;
`ifdef LOADER_CHECKSUM_EN
            w_sum_next   = '0;
`endif
            w_state_next = DATA;
          end
        end
      end
      DATA: begin
        if (w_byte_valid) begin
          if (!w_frame_ok) begin
            w_state_next = ERR;
            w_err_next   = 1'b1;
          end else begin
            w_data_next = w_rx_byte;
            w_we_next   = 1'b1;
            w_cnt_next  = r_cnt + 9'd1;
`ifdef LOADER_CHECKSUM_EN
            w_sum_next  = r_sum + w_rx_byte;
            if (r_cnt + 9'd1 == r_len) w_state_next = CSUM;
`else
            if (r_cnt + 9'd1 == r_len) begin
              w_state_next = DONE;
              w_hold_next  = 1'b0;
              w_done_next  = 1'b1;
            end
`endif
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (w_byte_valid) begin
          if (w_frame_ok && (w_rx_byte == r_sum)) begin
            w_state_next = DONE;
            w_hold_next  = 1'b0;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = ERR;
            w_err_next   = 1'b1;
          end
        end
      end
`endif
      default: w_state_next = IDLE;
    endcase
  end

  assign bus.ram_addr  = r_addr;
  assign bus.ram_data  = r_data;
  assign bus.ram_we    = r_we;
  assign bus.cpu_hold  = r_hold;
  assign bus.load_done = r_done;
  assign bus.load_err  = r_err;
  assign bus.byte_cnt  = r_cnt;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader. BRAM writes are checked by a
// scoreboard: expected (addr, data) pairs are queued as bytes are sent and
// popped as ram_we pulses appear. A reduced baud divisor keeps runs short.
module tb_uart_prog_loader;

  localparam int CLK_HZ = 1_200_000;
  localparam int BAUD   = 100_000;
  localparam int DIVB   = CLK_HZ / BAUD;   // 12 clocks per bit
  localparam int ADDR_W = 11;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd   = 1'b1;

  uart_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rxd   (rxd),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Scoreboard: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && bus.ram_we) begin
      wr_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h, expected no write",
                 bus.ram_addr, bus.ram_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.ram_addr !== e.a || bus.ram_data !== e.d) begin
          n_bad++;
          $display("FAIL write: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                   bus.ram_addr, bus.ram_data, e.a, e.d);
        end else begin
          $display("write addr=%0h data=%0h ok", bus.ram_addr, bus.ram_data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (DIVB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIVB) @(negedge clk);
    end
    rxd = stop;
    repeat (DIVB) @(negedge clk);
    rxd = 1'b1;
    if (!stop) repeat (2 * DIVB) @(negedge clk);
  endtask

  task automatic settle();
    repeat (2 * DIVB) @(negedge clk);
  endtask

  // Sends A5, length byte, data (queuing expected writes), then checksum
  // (plus csum_delta) when the checksum feature is built in.
  task automatic send_frame(input logic [7:0] len_b, input logic [7:0] data[$],
                            input logic [7:0] csum_delta);
    logic [7:0] sum;
    sum = 8'd0;
    send_byte(8'hA5, 1'b1);
    send_byte(len_b, 1'b1);
    for (int i = 0; i < data.size(); i++) begin
      exp_q.push_back('{a: ADDR_W'(i), d: data[i]});
      sum = sum + data[i];
      send_byte(data[i], 1'b1);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(sum + csum_delta, 1'b1);
`else
    if (csum_delta != 8'd0) $display("note: checksum feature not built, no checksum byte sent");
`endif
    settle();
  endtask

  task automatic check_status(input string name, input logic hold, input logic done,
                              input logic err, input logic [8:0] cnt);
    n_cmp++;
    if (bus.cpu_hold !== hold || bus.load_done !== done ||
        bus.load_err !== err || bus.byte_cnt !== cnt || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: got hold=%b done=%b err=%b cnt=%0d pending=%0d, expected hold=%b done=%b err=%b cnt=%0d pending=0",
               name, bus.cpu_hold, bus.load_done, bus.load_err, bus.byte_cnt,
               exp_q.size(), hold, done, err, cnt);
    end else begin
      $display("%s: hold=%b done=%b err=%b cnt=%0d ok", name, hold, done, err, cnt);
    end
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if (bus.ram_addr !== '0 || bus.ram_data !== 8'd0 || bus.ram_we !== 1'b0 ||
        bus.cpu_hold !== 1'b0 || bus.load_done !== 1'b0 || bus.load_err !== 1'b0 ||
        bus.byte_cnt !== 9'd0) begin
      n_bad++;
      $display("FAIL %s: got addr=%0h data=%0h we=%b hold=%b done=%b err=%b cnt=%0d, expected all zero",
               name, bus.ram_addr, bus.ram_data, bus.ram_we, bus.cpu_hold,
               bus.load_done, bus.load_err, bus.byte_cnt);
    end else begin
      $display("%s: all outputs zero ok", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset_held");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset_released");
  endtask

  task automatic test_basic();
    logic [7:0] d[$];
    d = '{8'h11, 8'h22, 8'h33};
    send_byte(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    check_status("basic_hold_after_sync", 1'b1, 1'b0, 1'b0, 9'd0);
    send_byte(8'h03, 1'b1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{a: ADDR_W'(i), d: d[i]});
      send_byte(d[i], 1'b1);
    end
`ifdef LOADER_CHECKSUM_EN
    settle();
    check_status("basic_wait_csum", 1'b1, 1'b0, 1'b0, 9'd3);
    send_byte(8'h66, 1'b1);
`endif
    settle();
    check_status("basic_done", 1'b0, 1'b1, 1'b0, 9'd3);
  endtask

  task automatic test_bad_checksum();
    logic [7:0] d[$];
`ifdef LOADER_CHECKSUM_EN
    d = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h03, d, 8'h01);
    check_status("bad_csum_err", 1'b1, 1'b0, 1'b1, 9'd3);
`endif
    d = '{8'h42};
    send_frame(8'h01, d, 8'h00);
    check_status("recover_done", 1'b0, 1'b1, 1'b0, 9'd1);
  endtask

  task automatic test_full_256();
    logic [7:0] d[$];
    for (int i = 0; i < 256; i++) d.push_back(8'(i));
    send_frame(8'h00, d, 8'h00);
    check_status("full_256", 1'b0, 1'b1, 1'b0, 9'd256);
  endtask

  task automatic test_framing();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    exp_q.push_back('{a: ADDR_W'(0), d: 8'h11});
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    settle();
    check_status("framing_err", 1'b1, 1'b0, 1'b1, 9'd1);
  endtask

  task automatic test_glitch();
    rxd = 1'b0;
    repeat (DIVB / 4) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * DIVB) @(negedge clk);
    check_status("glitch_ignored", 1'b1, 1'b0, 1'b1, 9'd1);
  endtask

  task automatic test_reset_midframe();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    exp_q.push_back('{a: ADDR_W'(0), d: 8'hC1});
    send_byte(8'hC1, 1'b1);
    exp_q.push_back('{a: ADDR_W'(1), d: 8'hC2});
    send_byte(8'hC2, 1'b1);
    repeat (6) @(negedge clk);
    check_status("midframe_before_reset", 1'b1, 1'b0, 1'b0, 9'd2);
    rst_n = 1'b0;
    #1;
    check_zero("midframe_reset_immediate");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    settle();
    check_zero("no_sync_no_write");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_checksum();
    test_full_256();
    test_framing();
    test_glitch();
    test_reset_midframe();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Serial program loader that receives a framed byte stream on a UART line and writes it into the program BRAM through its otherwise unused port B, filling the memory the CPU fetches from on port A. It holds the CPU stalled (`cpu_hold`) while a load is in progress and releases it once the frame is accepted. It sits beside the CPU core at top level, sharing the board clock.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency in Hz.
- `BAUD`, 115200, serial bit rate; bit period `DIV = CLK_HZ / BAUD`, truncated (434 at defaults).
- `ADDR_W`, 11, BRAM port B address width.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rxd`  in  1  UART receive line, idle high, 8N1, LSB first; asynchronous to `clk`.
- `ram_addr`  out  ADDR_W  port B write address.
- `ram_data`  out  8  port B write data.
- `ram_we`  out  1  port B write enable, one-cycle pulse per data byte.
- `cpu_hold`  out  1  high while a load is in progress or failed; CPU must not advance its PC.
- `load_done`  out  1  high after a frame is accepted; cleared by the next sync byte.
- `load_err`  out  1  high after a framing or checksum failure; cleared by the next sync byte.
- `byte_cnt`  out  9  data bytes written in the current or last frame (1..256).

## Operation
- `rxd` passes a 2-flop synchronizer before any use.
- Byte receiver:
  - A falling edge in idle starts a counter.
  - At `DIV/2` the line is re-sampled; if it is high, this is a glitch and the receiver returns to idle.
  - Each following bit is sampled every `DIV` clocks: 8 data bits, then the stop bit.
  - On the stop sample it emits `byte_valid` for one cycle, with `byte` and `frame_ok` (stop bit = 1).
  - It is ready for a new start edge on the next cycle.
- Frame format: `0xA5` sync, length `L` (0 means 256), `L` data bytes, then an 8-bit checksum. The checksum is the mod-256 sum of the data bytes.
- FSM states and transitions:
  - IDLE: `0xA5` → LEN and asserts `cpu_hold`; any other byte is ignored.
  - LEN: latches `L`, clears the address and checksum → DATA.
  - DATA: on each byte, drives `ram_addr`/`ram_data` and pulses `ram_we`, increments the address and `byte_cnt`, and accumulates the sum. After byte `L` → CSUM.
  - CSUM: match → DONE; mismatch → ERR.
  - DONE: `cpu_hold` = 0, `load_done` = 1. A `0xA5` here → LEN, clearing `load_done` and asserting `cpu_hold`.
  - ERR: `cpu_hold` = 1, `load_err` = 1. A `0xA5` here → LEN, clearing `load_err`.
- A byte with `frame_ok` = 0 in LEN, DATA or CSUM → ERR, and the byte is not written. In IDLE, DONE and ERR such bytes are ignored.
- Bytes written before an error remain in BRAM; there is no rollback.
- `ram_addr` wraps modulo 2^ADDR_W. Loads use at most 256 addresses, starting at 0.

## Timing
- Reset values: `ram_addr` = 0, `ram_data` = 0, `ram_we` = 0, `cpu_hold` = 0, `load_done` = 0, `load_err` = 0, `byte_cnt` = 0; FSM in IDLE; receiver idle.
- `ram_we` is asserted in the cycle after `byte_valid`, with address and data stable in that same cycle. Address and data change only on the cycle after the pulse.
- `cpu_hold` rises 1 cycle after the sync byte's `byte_valid`. It falls 1 cycle after the checksum byte's `byte_valid`.
- Latency from the `rxd` stop-bit midpoint to `ram_we` is 4 cycles: 2 synchronizer, 1 decode, 1 write.
- `rst_n` asserted mid-frame aborts immediately and returns all outputs to reset values; the next frame needs a fresh sync byte.

## Configuration
- `LOADER_CHECKSUM_EN` defined: the CSUM state and checksum comparison are present, as described above.
- `LOADER_CHECKSUM_EN` undefined: no checksum byte is expected; after data byte `L` the FSM goes directly to DONE. ERR is then reachable only through a framing error.

## Structure
- Shared package `loader_pkg`:
  - Sync constant `LDR_SYNC = 8'hA5`.
  - FSM state enum `{IDLE, LEN, DATA, CSUM, DONE, ERR}`.
  - Divisor function `DIV(CLK_HZ, BAUD)`.
- One sub-module: `uart_rx_byte`, containing the synchronizer, bit timer and shift register, with outputs `byte_valid`/`byte`/`frame_ok`. The frame FSM lives in `uart_prog_loader`.

## Test plan
- Defaults (`DIV` = 434), `LOADER_CHECKSUM_EN` on. Send `A5 03 11 22 33 66` → three `ram_we` pulses at addr 0/1/2 with data 11/22/33; `load_done` = 1, `cpu_hold` = 0, `byte_cnt` = 3.
- Same frame with checksum `67` → writes occur; `load_err` = 1, `cpu_hold` = 1. Then send `A5 01 42 42` → `load_err` = 0, `load_done` = 1, addr 0 = 42.
- Length byte `00` followed by 256 bytes of value i → 256 writes, the last at addr 255; `byte_cnt` = 256.
- Stop bit forced to 0 on the second data byte → one write only; ERR state; `load_err` = 1.
- Low glitch of `DIV/4` clocks on idle `rxd` → no `byte_valid`; outputs unchanged.
- `rst_n` pulsed low after two data bytes → all outputs 0 immediately. A following `12 34` without sync → no writes.
